sysctrl_gen: RTL and testbench

//  Parametrised MCU system-control slave; successor to the fixed-function core control block.

---
 rtl/sysctrl_pkg.sv | 25 ++
 rtl/sysctrl_irq.sv | 52 +++++
 rtl/sysctrl_gen.sv | 175 +++++++++++++++++
 tb/tb_sysctrl_gen.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sysctrl_pkg.sv
// Shared command codes, status magic bytes and helpers for the system-control slave.
package sysctrl_pkg;

  localparam logic [7:0] CMD_STATUS  = 8'h00;
  localparam logic [7:0] CMD_LEDS    = 8'h01;
  localparam logic [7:0] CMD_COLOR   = 8'h02;
  localparam logic [7:0] CMD_BUTTONS = 8'h03;
  localparam logic [7:0] CMD_CFG_WR  = 8'h04;
  localparam logic [7:0] CMD_INT     = 8'h05;
  localparam logic [7:0] CMD_INTMASK = 8'h06;
  localparam logic [7:0] CMD_CFG_RD  = 8'h07;

  localparam logic [7:0] STATUS_MAGIC0 = 8'h5c;
  localparam logic [7:0] STATUS_MAGIC1 = 8'h42;

  // The MCU sends colour bytes LSB-first relative to the ws2812 bit order.
  function automatic logic [7:0] bit_rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[7-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/sysctrl_irq.sv
// Latched, maskable interrupt channels with per-channel acknowledge pulses.
module sysctrl_irq
  import sysctrl_pkg::*;
#(
  parameter int unsigned NUM_INT = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_INT-1:0] int_i,
  input  logic [NUM_INT-1:0] clr_i,
  input  logic               mask_we_i,
  input  logic [NUM_INT-1:0] mask_wdata_i,
  output logic [NUM_INT-1:0] pending_o,
  output logic [NUM_INT-1:0] mask_o,
  output logic [NUM_INT-1:0] ack_o,
  output logic               irq_no
);

  logic [NUM_INT-1:0] pending_d, pending_q;
  logic [NUM_INT-1:0] mask_d, mask_q;
  logic [NUM_INT-1:0] ack_d, ack_q;
  logic               irq_n_d, irq_n_q;

  // Next state: a new request wins over a same-cycle clear; IRQ follows pending one cycle later.
  always_comb begin
    pending_d = int_i | (pending_q & ~clr_i);
    mask_d    = mask_we_i ? mask_wdata_i : mask_q;
    ack_d     = clr_i;
    irq_n_d   = ~|(pending_q & mask_q);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pending_q <= '0;
      mask_q    <= '1;
      ack_q     <= '0;
      irq_n_q   <= 1'b1;
    end else begin
      pending_q <= pending_d;
      mask_q    <= mask_d;
      ack_q     <= ack_d;
      irq_n_q   <= irq_n_d;
    end
  end

  assign pending_o = pending_q;
  assign mask_o    = mask_q;
  assign ack_o     = ack_q;
  assign irq_no    = irq_n_q;

endmodule

// File: rtl/sysctrl_gen.sv
// MCU system-control slave: framed byte command decoder driving LEDs, colour,
// config register file and interrupt control.
module sysctrl_gen
  import sysctrl_pkg::*;
#(
  parameter logic [7:0]           CORE_ID     = 8'h01,
  parameter int unsigned          NUM_LEDS    = 2,
  parameter int unsigned          NUM_BTNS    = 2,
  parameter int unsigned          NUM_INT     = 8,
  parameter int unsigned          NUM_CFG     = 16,
  parameter logic [NUM_CFG*8-1:0] CFG_DEFAULT = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 data_in_strobe,
  input  logic                 data_in_start,
  input  logic [7:0]           data_in,
  output logic [7:0]           data_out,
  output logic                 int_out_n,
  input  logic [NUM_INT-1:0]   int_in,
  output logic [NUM_INT-1:0]   int_ack,
  input  logic [NUM_BTNS-1:0]  buttons,
  output logic [NUM_LEDS-1:0]  leds,
  output logic [23:0]          color,
  output logic [NUM_CFG*8-1:0] cfg,
  output logic [NUM_CFG-1:0]   cfg_wr
);

  localparam int unsigned IW       = (NUM_CFG > 2) ? $clog2(NUM_CFG) : 1;
  localparam logic [8:0]  NumCfgW  = 9'(NUM_CFG);
  localparam logic [7:0]  CfgLast  = 8'(NUM_CFG - 1);

  logic [7:0]          cmd_d, cmd_q;
  logic [7:0]          idx_d, idx_q;
  logic [7:0]          ptr_d, ptr_q;
  logic [7:0]          data_out_d, data_out_q;
  logic [NUM_LEDS-1:0] leds_d, leds_q;
  logic [23:0]         color_d, color_q;
  logic [7:0]          cfg_d [NUM_CFG];
  logic [7:0]          cfg_q [NUM_CFG];
  logic [NUM_CFG-1:0]  cfg_wr_d, cfg_wr_q;

  logic                payload;
  logic [7:0]          rd_ptr;
  logic [NUM_INT-1:0]  irq_clr;
  logic                mask_we;
  logic [NUM_INT-1:0]  pending;
  logic [NUM_INT-1:0]  mask;

  // Command decode: start bytes open a frame, payload bytes act by position within it.
  always_comb begin
    cmd_d      = cmd_q;
    idx_d      = idx_q;
    ptr_d      = ptr_q;
    data_out_d = data_out_q;
    leds_d     = leds_q;
    color_d    = color_q;
    cfg_d      = cfg_q;
    cfg_wr_d   = '0;
    irq_clr    = '0;
    mask_we    = 1'b0;
    payload    = data_in_strobe & ~data_in_start & (idx_q != 8'd0);
    // CFG_RD reads at the pointer value this byte leaves behind.
    rd_ptr     = (idx_q == 8'd1) ? data_in : ptr_q + 8'd1;

    if (data_in_strobe && data_in_start) begin
      cmd_d      = data_in;
      idx_d      = 8'd1;
      data_out_d = '0;
    end else if (payload) begin
      data_out_d = '0;
      if (idx_q != 8'hff) begin
        idx_d = idx_q + 8'd1;
      end
      case (cmd_q)
        CMD_STATUS: begin
          case (idx_q)
            8'd1:    data_out_d = STATUS_MAGIC0;
            8'd2:    data_out_d = STATUS_MAGIC1;
            8'd3:    data_out_d = CORE_ID;
            8'd4:    data_out_d = CfgLast;
            default: data_out_d = '0;
          endcase
        end
        CMD_LEDS: begin
          if (idx_q == 8'd1) leds_d = data_in[NUM_LEDS-1:0];
        end
        CMD_COLOR: begin
          case (idx_q)
            8'd1:    color_d[15:8]  = bit_rev8(data_in);
            8'd2:    color_d[7:0]   = bit_rev8(data_in);
            8'd3:    color_d[23:16] = bit_rev8(data_in);
            default: ;
          endcase
        end
        CMD_BUTTONS: begin
          data_out_d[NUM_BTNS-1:0] = buttons;
        end
        CMD_CFG_WR: begin
          if (idx_q == 8'd1) begin
            ptr_d = data_in;
          end else begin
            if ({1'b0, ptr_q} < NumCfgW) begin
              cfg_d[ptr_q[IW-1:0]]    = data_in;
              cfg_wr_d[ptr_q[IW-1:0]] = 1'b1;
            end
            ptr_d = ptr_q + 8'd1;
          end
        end
        CMD_INT: begin
          if (idx_q == 8'd1) irq_clr = data_in[NUM_INT-1:0];
          data_out_d[NUM_INT-1:0] = pending & mask;
        end
        CMD_INTMASK: begin
          if (idx_q == 8'd1) mask_we = 1'b1;
        end
        CMD_CFG_RD: begin
          ptr_d = rd_ptr;
          if ({1'b0, rd_ptr} < NumCfgW) data_out_d = cfg_q[rd_ptr[IW-1:0]];
        end
        default: ;
      endcase
    end
  end

  // Frame, output and config registers; reset drops any frame in progress.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cmd_q      <= '0;
      idx_q      <= '0;
      ptr_q      <= '0;
      data_out_q <= '0;
      leds_q     <= '0;
      color_q    <= '0;
      cfg_wr_q   <= '0;
      for (int i = 0; i < NUM_CFG; i++) begin
        cfg_q[i] <= CFG_DEFAULT[8*i +: 8];
      end
    end else begin
      cmd_q      <= cmd_d;
      idx_q      <= idx_d;
      ptr_q      <= ptr_d;
      data_out_q <= data_out_d;
      leds_q     <= leds_d;
      color_q    <= color_d;
      cfg_wr_q   <= cfg_wr_d;
      cfg_q      <= cfg_d;
    end
  end

  sysctrl_irq #(
    .NUM_INT (NUM_INT)
  ) u_irq (
    .clk_i        (clk),
    .rst_ni       (reset_n),
    .int_i        (int_in),
    .clr_i        (irq_clr),
    .mask_we_i    (mask_we),
    .mask_wdata_i (data_in[NUM_INT-1:0]),
    .pending_o    (pending),
    .mask_o       (mask),
    .ack_o        (int_ack),
    .irq_no       (int_out_n)
  );

  for (genvar gi = 0; gi < NUM_CFG; gi++) begin : g_cfg
    assign cfg[8*gi +: 8] = cfg_q[gi];
  end

  assign data_out = data_out_q;
  assign leds     = leds_q;
  assign color    = color_q;
  assign cfg_wr   = cfg_wr_q;

endmodule

// File: tb/tb_sysctrl_gen.sv
// Directed bench for sysctrl_gen: table of framed readback vectors plus
// hand-written sequences for config writes, interrupts, colour and reset.
module tb_sysctrl_gen;

  localparam logic [7:0]   CoreId     = 8'h3c;
  localparam int unsigned  NumLeds    = 2;
  localparam int unsigned  NumBtns    = 2;
  localparam int unsigned  NumInt     = 8;
  localparam int unsigned  NumCfg     = 16;
  localparam logic [127:0] CfgDefault = {8'h5a, 112'h0, 8'ha5};

  logic               clk = 1'b0;
  logic               reset_n;
  logic               data_in_strobe;
  logic               data_in_start;
  logic [7:0]         data_in;
  logic [7:0]         data_out;
  logic               int_out_n;
  logic [NumInt-1:0]  int_in;
  logic [NumInt-1:0]  int_ack;
  logic [NumBtns-1:0] buttons;
  logic [NumLeds-1:0] leds;
  logic [23:0]        color;
  logic [127:0]       cfg;
  logic [NumCfg-1:0]  cfg_wr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sysctrl_gen #(
    .CORE_ID     (CoreId),
    .NUM_LEDS    (NumLeds),
    .NUM_BTNS    (NumBtns),
    .NUM_INT     (NumInt),
    .NUM_CFG     (NumCfg),
    .CFG_DEFAULT (CfgDefault)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .data_in_strobe (data_in_strobe),
    .data_in_start  (data_in_start),
    .data_in        (data_in),
    .data_out       (data_out),
    .int_out_n      (int_out_n),
    .int_in         (int_in),
    .int_ack        (int_ack),
    .buttons        (buttons),
    .leds           (leds),
    .color          (color),
    .cfg            (cfg),
    .cfg_wr         (cfg_wr)
  );

  typedef struct packed {
    logic       st;
    logic [7:0] d;
    logic       chk;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one strobed byte; returns 1 time unit after the capturing edge.
  task automatic send(input logic st, input logic [7:0] d);
    data_in_strobe = 1'b1;
    data_in_start  = st;
    data_in        = d;
    @(posedge clk); #1;
    data_in_strobe = 1'b0;
    data_in_start  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic vec_t mk(input logic st, input logic [7:0] d, input logic chk,
                              input logic [7:0] exp);
    vec_t v;
    v.st = st; v.d = d; v.chk = chk; v.exp = exp;
    return v;
  endfunction

  initial begin
    reset_n        = 1'b0;
    data_in_strobe = 1'b0;
    data_in_start  = 1'b0;
    data_in        = 8'h00;
    int_in         = '0;
    buttons        = 2'b10;
    tick();
    tick();

    // Reset state
    check("rst_leds", 128'(leds), 128'h0);
    check("rst_color", 128'(color), 128'h0);
    check("rst_data_out", 128'(data_out), 128'h0);
    check("rst_int_ack", 128'(int_ack), 128'h0);
    check("rst_cfg_wr", 128'(cfg_wr), 128'h0);
    check("rst_cfg", cfg, CfgDefault);
    check("rst_int_out_n", 128'(int_out_n), 128'h1);
    reset_n = 1'b1;
    tick();

    // Burst config write 04,03,11,22,33
    send(1'b1, 8'h04);
    send(1'b0, 8'h03);
    check("cfgwr_no_pulse_on_ptr", 128'(cfg_wr), 128'h0);
    send(1'b0, 8'h11);
    check("cfgwr_pulse3", 128'(cfg_wr), 128'h0008);
    send(1'b0, 8'h22);
    check("cfgwr_pulse4", 128'(cfg_wr), 128'h0010);
    send(1'b0, 8'h33);
    check("cfgwr_pulse5", 128'(cfg_wr), 128'h0020);
    tick();
    check("cfgwr_idle", 128'(cfg_wr), 128'h0);
    check("cfg_regs_3_5", 128'(cfg[47:24]), 128'h332211);
    check("cfg_reg0_kept", 128'(cfg[7:0]), 128'ha5);

    // Write to last register, then past the end (dropped)
    send(1'b1, 8'h04);
    send(1'b0, 8'h0f);
    send(1'b0, 8'h77);
    check("cfgwr_pulse15", 128'(cfg_wr), 128'h8000);
    send(1'b0, 8'h88);
    check("cfgwr_oob_no_pulse", 128'(cfg_wr), 128'h0);
    check("cfg_reg15", 128'(cfg[127:120]), 128'h77);

    // Readback table
    vecs.push_back(mk(1'b1, 8'h00, 1'b0, 8'h00));
    vecs.push_back(mk(1'b0, 8'h00, 1'b1, 8'h5c));
    vecs.push_back(mk(1'b0, 8'h00, 1'b1, 8'h42));
    vecs.push_back(mk(1'b0, 8'h00, 1'b1, CoreId));
    vecs.push_back(mk(1'b0, 8'h00, 1'b1, 8'h0f));
    vecs.push_back(mk(1'b0, 8'h00, 1'b1, 8'h00));
    vecs.push_back(mk(1'b1, 8'h03, 1'b0, 8'h00));
    vecs.push_back(mk(1'b0, 8'h00, 1'b1, 8'h02));
    vecs.push_back(mk(1'b0, 8'h00, 1'b1, 8'h02));
    vecs.push_back(mk(1'b1, 8'h07, 1'b0, 8'h00));
    vecs.push_back(mk(1'b0, 8'h03, 1'b1, 8'h11));
    vecs.push_back(mk(1'b0, 8'hff, 1'b1, 8'h22));
    vecs.push_back(mk(1'b0, 8'hff, 1'b1, 8'h33));
    vecs.push_back(mk(1'b1, 8'h07, 1'b0, 8'h00));
    vecs.push_back(mk(1'b0, 8'h10, 1'b1, 8'h00));
    vecs.push_back(mk(1'b1, 8'h07, 1'b0, 8'h00));
    vecs.push_back(mk(1'b0, 8'h0f, 1'b1, 8'h77));
    vecs.push_back(mk(1'b0, 8'h00, 1'b1, 8'h00));
    vecs.push_back(mk(1'b1, 8'h07, 1'b0, 8'h00));
    vecs.push_back(mk(1'b0, 8'h00, 1'b1, 8'ha5));
    vecs.push_back(mk(1'b0, 8'h00, 1'b1, 8'h00));
    vecs.push_back(mk(1'b1, 8'h07, 1'b0, 8'h00));
    vecs.push_back(mk(1'b0, 8'h03, 1'b1, 8'h11));
    vecs.push_back(mk(1'b1, 8'h00, 1'b0, 8'h00));
    vecs.push_back(mk(1'b0, 8'h00, 1'b1, 8'h5c));
    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i].st, vecs[i].d);
      if (vecs[i].chk) check($sformatf("vec%0d_data_out", i), 128'(data_out), 128'(vecs[i].exp));
    end

    // Interrupt latch and IRQ line
    int_in = 8'h04;
    tick();
    int_in = 8'h00;
    tick();
    check("irq_asserted", 128'(int_out_n), 128'h0);
    send(1'b1, 8'h05);
    int_in = 8'h04;
    send(1'b0, 8'h04);
    int_in = 8'h00;
    check("int_read_pending", 128'(data_out), 128'h04);
    check("int_ack_pulse", 128'(int_ack), 128'h04);
    tick();
    check("int_ack_one_cycle", 128'(int_ack), 128'h0);
    check("irq_set_wins", 128'(int_out_n), 128'h0);
    send(1'b1, 8'h05);
    send(1'b0, 8'h04);
    check("int_ack_clear", 128'(int_ack), 128'h04);
    tick();
    tick();
    check("irq_cleared", 128'(int_out_n), 128'h1);

    // Masking
    send(1'b1, 8'h06);
    send(1'b0, 8'h00);
    int_in = 8'h02;
    tick();
    int_in = 8'h00;
    tick();
    tick();
    check("irq_masked", 128'(int_out_n), 128'h1);
    send(1'b1, 8'h05);
    send(1'b0, 8'h00);
    check("int_read_masked", 128'(data_out), 128'h00);
    send(1'b1, 8'h06);
    send(1'b0, 8'hff);
    tick();
    check("irq_unmasked", 128'(int_out_n), 128'h0);
    send(1'b1, 8'h05);
    send(1'b0, 8'h02);
    check("int_read_unmasked", 128'(data_out), 128'h02);

    // LEDs
    send(1'b1, 8'h01);
    send(1'b0, 8'h03);
    check("leds_set", 128'(leds), 128'h3);
    send(1'b0, 8'h00);
    check("leds_p2_ignored", 128'(leds), 128'h3);

    // Colour: 80->G=01, 40->B=02, C0->R=03, packed {R,G,B}
    send(1'b1, 8'h02);
    send(1'b0, 8'h80);
    send(1'b0, 8'h40);
    send(1'b0, 8'hc0);
    check("color", 128'(color), 128'h030102);

    // Reset mid-frame, then a stray payload byte must be ignored
    int_in = 8'h01;
    send(1'b1, 8'h04);
    int_in = 8'h00;
    send(1'b0, 8'h00);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("mid_rst_leds", 128'(leds), 128'h0);
    check("mid_rst_color", 128'(color), 128'h0);
    check("mid_rst_data_out", 128'(data_out), 128'h0);
    check("mid_rst_cfg", cfg, CfgDefault);
    check("mid_rst_int_out_n", 128'(int_out_n), 128'h1);
    send(1'b0, 8'h99);
    check("idle_no_cfg_wr", 128'(cfg_wr), 128'h0);
    check("idle_cfg_kept", cfg, CfgDefault);
    tick();
    check("idle_no_irq", 128'(int_out_n), 128'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
